// File: rtl/sirv_qspi_fifo_param.sv
// Parametrised QSPI frame FIFO between the register front-end and the link engine:
// TX/RX circular queues, beat-count generation, chip-select control and sticky status flags.
module sirv_qspi_fifo_param #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int LENW  = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      io_ctrl_fmt_proto,
  input  logic            io_ctrl_fmt_endian,
  input  logic            io_ctrl_fmt_iodir,
  input  logic [LENW-1:0] io_ctrl_fmt_len,
  input  logic [1:0]      io_ctrl_cs_mode,
  input  logic [CW-1:0]   io_ctrl_wm_tx,
  input  logic [CW-1:0]   io_ctrl_wm_rx,
  input  logic            io_ctrl_tx_flush,
  input  logic            io_ctrl_rx_flush,
  input  logic            io_ctrl_flag_clr,
  input  logic            io_link_tx_ready,
  output logic            io_link_tx_valid,
  output logic [DW-1:0]   io_link_tx_bits,
  input  logic            io_link_rx_valid,
  input  logic [DW-1:0]   io_link_rx_bits,
  output logic [7:0]      io_link_cnt,
  output logic [1:0]      io_link_fmt_proto,
  output logic            io_link_fmt_endian,
  output logic            io_link_fmt_iodir,
  output logic            io_link_cs_set,
  output logic            io_link_cs_clear,
  output logic            io_link_cs_hold,
  output logic            io_link_lock,
  input  logic            io_link_active,
  output logic            io_tx_ready,
  input  logic            io_tx_valid,
  input  logic [DW-1:0]   io_tx_bits,
  input  logic            io_rx_ready,
  output logic            io_rx_valid,
  output logic [DW-1:0]   io_rx_bits,
  output logic [CW-1:0]   io_tx_count,
  output logic [CW-1:0]   io_rx_count,
  output logic            io_ip_txwm,
  output logic            io_ip_rxwm,
  output logic            io_rx_overflow,
  output logic            io_tx_underrun
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (LENW > 8) ? LENW : 8;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [AW-1:0] ZERO_PTR = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [DW-1:0] tx_mem_q [DEPTH];
  logic [DW-1:0] rx_mem_q [DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          rxen_q, rxen_d;
  logic [1:0]    cs_mode_q, cs_mode_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_enq, fire_tx, rx_enq, rx_drop, rx_deq;
  logic [BW-1:0] len_ext, beats;
  logic unused_link_active;

  assign unused_link_active = io_link_active;

  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == ZERO_CNT);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == ZERO_CNT);

  assign io_tx_ready      = !tx_full;
  assign io_link_tx_valid = !tx_empty;
  assign io_link_tx_bits  = tx_mem_q[tx_rptr_q];
  assign io_rx_valid      = !rx_empty;
  assign io_rx_bits       = rx_mem_q[rx_rptr_q];

  assign tx_enq  = io_tx_valid & io_tx_ready;
  assign fire_tx = io_link_tx_ready & io_link_tx_valid;
  // Fullness is judged before this cycle's dequeue, so a same-cycle read cannot make room.
  assign rx_enq  = io_link_rx_valid & rxen_q & !rx_full;
  assign rx_drop = io_link_rx_valid & rxen_q & rx_full;
  assign rx_deq  = io_rx_ready & io_rx_valid;

  // TX queue pointer/count next state; flush overrides enqueue and dequeue
  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (io_ctrl_tx_flush) begin
      tx_wptr_d = ZERO_PTR;
      tx_rptr_d = ZERO_PTR;
      tx_cnt_d  = ZERO_CNT;
    end else begin
      if (tx_enq) tx_wptr_d = tx_wptr_q + ONE_PTR;
      else        tx_wptr_d = tx_wptr_q;
      if (fire_tx) tx_rptr_d = tx_rptr_q + ONE_PTR;
      else         tx_rptr_d = tx_rptr_q;
      case ({tx_enq, fire_tx})
        2'b10:   tx_cnt_d = tx_cnt_q + ONE_CNT;
        2'b01:   tx_cnt_d = tx_cnt_q - ONE_CNT;
        default: tx_cnt_d = tx_cnt_q;
      endcase
    end
  end

  // RX queue pointer/count next state; flush overrides enqueue and dequeue
  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (io_ctrl_rx_flush) begin
      rx_wptr_d = ZERO_PTR;
      rx_rptr_d = ZERO_PTR;
      rx_cnt_d  = ZERO_CNT;
    end else begin
      if (rx_enq) rx_wptr_d = rx_wptr_q + ONE_PTR;
      else        rx_wptr_d = rx_wptr_q;
      if (rx_deq) rx_rptr_d = rx_rptr_q + ONE_PTR;
      else        rx_rptr_d = rx_rptr_q;
      case ({rx_enq, rx_deq})
        2'b10:   rx_cnt_d = rx_cnt_q + ONE_CNT;
        2'b01:   rx_cnt_d = rx_cnt_q - ONE_CNT;
        default: rx_cnt_d = rx_cnt_q;
      endcase
    end
  end

  // Capture enable, chip-select mode tracking and sticky flags
  always_comb begin
    rxen_d    = rxen_q;
    cs_mode_d = io_ctrl_cs_mode;
    if (fire_tx)               rxen_d = !io_ctrl_fmt_iodir;
    else if (io_link_rx_valid) rxen_d = 1'b0;
    else                       rxen_d = rxen_q;
    ovf_d = rx_drop | (ovf_q & !io_ctrl_flag_clr);
    unf_d = (!rxen_q & tx_empty & io_link_tx_ready & (cs_mode_q == 2'd2))
          | (unf_q & !io_ctrl_flag_clr);
  end

  // Control/status registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_wptr_q <= ZERO_PTR;
      tx_rptr_q <= ZERO_PTR;
      tx_cnt_q  <= ZERO_CNT;
      rx_wptr_q <= ZERO_PTR;
      rx_rptr_q <= ZERO_PTR;
      rx_cnt_q  <= ZERO_CNT;
      rxen_q    <= 1'b0;
      cs_mode_q <= 2'd0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      rxen_q    <= rxen_d;
      cs_mode_q <= cs_mode_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Queue storage; contents are meaningless whenever the count says empty
  always_ff @(posedge clock) begin
    if (tx_enq) tx_mem_q[tx_wptr_q] <= io_tx_bits;
    if (rx_enq) rx_mem_q[rx_wptr_q] <= io_link_rx_bits;
  end

  // Beats per frame: ceil(len / lanes) as quotient plus a carry for any remainder
  always_comb begin
    len_ext = BW'(io_ctrl_fmt_len);
    case (io_ctrl_fmt_proto)
      2'd0:    beats = len_ext;
      2'd1:    beats = (len_ext >> 2'd1) + BW'(len_ext[0]);
      2'd2:    beats = (len_ext >> 2'd2) + BW'(|len_ext[1:0]);
      2'd3:    beats = (len_ext >> 2'd3) + BW'(|len_ext[2:0]);
      default: beats = len_ext;
    endcase
  end

  assign io_link_cnt        = beats[7:0];
  assign io_link_fmt_proto  = io_ctrl_fmt_proto;
  assign io_link_fmt_endian = io_ctrl_fmt_endian;
  assign io_link_fmt_iodir  = io_ctrl_fmt_iodir;
  assign io_link_cs_set     = (cs_mode_q != 2'd3);
  assign io_link_cs_clear   = (cs_mode_q != io_ctrl_cs_mode) | (fire_tx & (cs_mode_q < 2'd2));
  assign io_link_cs_hold    = 1'b0;
  assign io_link_lock       = io_link_tx_valid | rxen_q;
  assign io_tx_count        = tx_cnt_q;
  assign io_rx_count        = rx_cnt_q;
  assign io_ip_txwm         = (tx_cnt_q < io_ctrl_wm_tx);
  assign io_ip_rxwm         = (rx_cnt_q > io_ctrl_wm_rx);
  assign io_rx_overflow     = ovf_q;
  assign io_tx_underrun     = unf_q;

endmodule
